// File: rtl/ld_str_mem_access_stage_if.sv
// Single-port data-memory request/ack bus between the load/store access stage and memory.
// The stage is the master; the memory side acks each request with a one-cycle strobe.
interface ld_str_mem_access_stage_if;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic        mem_ack_in;
  logic [31:0] mem_rdata_in;

  modport master (
    output mem_req_out,
    output mem_we_out,
    output mem_addr_out,
    output mem_wdata_out,
    input  mem_ack_in,
    input  mem_rdata_in
  );

  modport slave (
    input  mem_req_out,
    input  mem_we_out,
    input  mem_addr_out,
    input  mem_wdata_out,
    output mem_ack_in,
    output mem_rdata_in
  );
endinterface

// File: rtl/ld_str_mem_access_stage.sv
// Load/store memory-access stage: issues one word access per register (LDR/STR or LDM/STM),
// returns load data to writeback and pulses retire once per instruction.
module ld_str_mem_access_stage #(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      req_valid_in,
  output logic                      req_ready_out,
  input  logic [31:0]               req_addr_in,
  input  logic [TAG_W-1:0]          req_tag_in,
  input  logic [3:0]                req_rd_addr_in,
  input  logic                      req_is_store_in,
  input  logic [31:0]               req_store_data_in,
  input  logic                      req_exec_in,
  input  logic                      req_multiple_en_in,
  input  logic [15:0]               req_reg_list_in,
  output logic [3:0]                rf_rd_addr_out,
  input  logic [31:0]               rf_rd_data_in,
  ld_str_mem_access_stage_if.master mem_io,
  output logic                      wb_valid_out,
  output logic [3:0]                wb_rd_addr_out,
  output logic [31:0]               wb_data_out,
  output logic [TAG_W-1:0]          wb_tag_out,
  output logic                      retire_valid_out,
  output logic [TAG_W-1:0]          retire_tag_out,
  output logic                      err_out
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CntW-1:0] WaitLast = CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              is_store_q, is_store_d;
  logic [31:0]       store_data_q, store_data_d;
  logic              multiple_q, multiple_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              wb_valid_q, wb_valid_d;
  logic [3:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic              retire_valid_q, retire_valid_d;
  logic [TAG_W-1:0]  retire_tag_q, retire_tag_d;
  logic              err_q, err_d;
  logic [3:0]        cur_reg;

  // Lowest set bit of the remaining list; descending scan so the lowest index wins.
  always_comb begin
    cur_reg = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (remaining_q[i]) cur_reg = 4'(i);
    end
  end

  assign req_ready_out         = (state_q == StIdle) && reset_in;
  assign rf_rd_addr_out        = cur_reg;
  assign mem_io.mem_req_out    = (state_q == StAccess);
  assign mem_io.mem_we_out     = (state_q == StAccess) && is_store_q;
  assign mem_io.mem_addr_out   = addr_q;
  assign mem_io.mem_wdata_out  = multiple_q ? rf_rd_data_in : store_data_q;
  assign wb_valid_out          = wb_valid_q;
  assign wb_rd_addr_out        = wb_rd_q;
  assign wb_data_out           = wb_data_q;
  assign wb_tag_out            = wb_tag_q;
  assign retire_valid_out      = retire_valid_q;
  assign retire_tag_out        = retire_tag_q;
  assign err_out               = err_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    tag_d          = tag_q;
    is_store_d     = is_store_q;
    store_data_d   = store_data_q;
    multiple_d     = multiple_q;
    remaining_d    = remaining_q;
    wait_d         = wait_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    wb_tag_d       = wb_tag_q;
    retire_valid_d = 1'b0;
    retire_tag_d   = retire_tag_q;
    err_d          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_in && req_ready_out) begin
          addr_d       = {req_addr_in[31:2], 2'b00};
          tag_d        = req_tag_in;
          is_store_d   = req_is_store_in;
          store_data_d = req_store_data_in;
          multiple_d   = req_multiple_en_in;
          wait_d       = '0;
          if (!req_exec_in || (req_multiple_en_in && (req_reg_list_in == 16'h0))) begin
            remaining_d    = 16'h0;
            retire_valid_d = 1'b1;
            retire_tag_d   = req_tag_in;
          end else begin
            remaining_d = req_multiple_en_in ? req_reg_list_in : (16'h1 << req_rd_addr_in);
            state_d     = StAccess;
          end
        end
      end
      StAccess: begin
        if (mem_io.mem_ack_in) begin
          if (!is_store_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = cur_reg;
            wb_data_d  = mem_io.mem_rdata_in;
            wb_tag_d   = tag_q;
          end
          remaining_d = remaining_q & ~(16'h1 << cur_reg);
          addr_d      = addr_q + 32'd4;
          wait_d      = '0;
          if (remaining_d == 16'h0) begin
            retire_valid_d = 1'b1;
            retire_tag_d   = tag_q;
            state_d        = StIdle;
          end
        end else if (TimeoutEn && (wait_q == WaitLast)) begin
          // Abort the rest of the instruction; earlier writebacks stand.
          remaining_d    = 16'h0;
          wait_d         = '0;
          err_d          = 1'b1;
          retire_valid_d = 1'b1;
          retire_tag_d   = tag_q;
          state_d        = StIdle;
        end else if (TimeoutEn) begin
          wait_d = wait_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      tag_q          <= '0;
      is_store_q     <= 1'b0;
      store_data_q   <= '0;
      multiple_q     <= 1'b0;
      remaining_q    <= '0;
      wait_q         <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_tag_q       <= '0;
      retire_valid_q <= 1'b0;
      retire_tag_q   <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      tag_q          <= tag_d;
      is_store_q     <= is_store_d;
      store_data_q   <= store_data_d;
      multiple_q     <= multiple_d;
      remaining_q    <= remaining_d;
      wait_q         <= wait_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_tag_q       <= wb_tag_d;
      retire_valid_q <= retire_valid_d;
      retire_tag_q   <= retire_tag_d;
      err_q          <= err_d;
    end
  end

endmodule
